// File: rtl/fifo_arb_ctrl.sv
// Two-requester, round-robin write arbiter and pointer/occupancy controller for an
// external 2^ADDR_W-entry memory with 1-cycle read latency and a sticky underflow flag.
module fifo_arb_ctrl #(
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic [7:0]        din0,
    input  logic              req1,
    input  logic [7:0]        din1,
    output logic              gnt0,
    output logic              gnt1,
    input  logic              rd_req,
    input  logic              err_clr,
    output logic              write_en,
    output logic [7:0]        data_in,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              read_en,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              udf_err
);

    localparam logic [ADDR_W:0] FullCount = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              last_q, last_d;  // 1: requester 1 was served last
    logic              rd_valid_q, rd_valid_d;
    logic              udf_q, udf_d;
    logic              pick1;

    always_comb begin
        full  = (count_q == FullCount);
        empty = (count_q == '0);

        // Gating with rst keeps grants quiet while the async reset is held.
        write_en = (req0 | req1) & ~full & ~rst;
        pick1    = req1 & (~req0 | ~last_q);
        gnt1     = write_en & pick1;
        gnt0     = write_en & ~pick1;
        data_in  = gnt0 ? din0 : (gnt1 ? din1 : 8'h00);
        read_en  = rd_req & ~empty & ~rst;

        wr_ptr_d   = write_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = read_en ? rd_ptr_q + 1'b1 : rd_ptr_q;
        last_d     = write_en ? gnt1 : last_q;
        rd_valid_d = read_en;

        count_d = count_q;
        if (write_en && !read_en) begin
            count_d = count_q + 1'b1;
        end else if (read_en && !write_en) begin
            count_d = count_q - 1'b1;
        end

        // Set has priority over clear.
        udf_d = udf_q;
        if (rd_req && empty) begin
            udf_d = 1'b1;
        end else if (err_clr) begin
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
            rd_valid_q <= rd_valid_d;
            udf_q      <= udf_d;
        end
    end

    assign wr_ptr   = wr_ptr_q;
    assign rd_ptr   = rd_ptr_q;
    assign count    = count_q;
    assign rd_valid = rd_valid_q;
    assign udf_err  = udf_q;

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Bench for fifo_arb_ctrl: directed vector table, multi-cycle corner sequences and a
// randomized run against a queue-based reference model with an attached memory.
module tb_fifo_arb_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, rd_req = 1'b0, err_clr = 1'b0;
    logic [7:0] din0 = 8'h00, din1 = 8'h00;
    logic       gnt0, gnt1, write_en, read_en, rd_valid, full, empty, udf_err;
    logic [7:0] data_in;
    logic [2:0] wr_ptr, rd_ptr;
    logic [3:0] count;

    logic [7:0] mem [8];
    logic [7:0] data_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_arb_ctrl #(.ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .din0(din0), .req1(req1), .din1(din1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rd_req(rd_req), .err_clr(err_clr),
        .write_en(write_en), .data_in(data_in), .wr_ptr(wr_ptr),
        .read_en(read_en), .rd_ptr(rd_ptr), .rd_valid(rd_valid),
        .full(full), .empty(empty), .count(count), .udf_err(udf_err)
    );

    // External memory the controller drives.
    always @(posedge clk) begin
        if (write_en) mem[wr_ptr] <= data_in;
        if (read_en) data_out <= mem[rd_ptr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit r0, input logic [7:0] d0, input bit r1,
                          input logic [7:0] d1, input bit rd, input bit clr);
        @(negedge clk);
        req0 = r0; din0 = d0; req1 = r1; din1 = d1; rd_req = rd; err_clr = clr;
        #1;
    endtask

    // Reference model: contents as a queue, pointers as total transfer counts mod 8.
    logic [7:0] mq[$];
    int         m_wr, m_rd;
    bit         m_last, m_udf, m_rv;
    logic [7:0] m_rdata;
    bit         e_we, e_g0, e_g1, e_re;
    logic [7:0] e_din;

    task automatic model_reset();
        mq.delete();
        m_wr = 0; m_rd = 0; m_last = 1'b1; m_udf = 1'b0; m_rv = 1'b0;
    endtask

    task automatic model_comb();
        int winner;
        e_we = (req0 || req1) && (mq.size() < 8);
        if (req0 && req1) winner = m_last ? 0 : 1;
        else winner = req1 ? 1 : 0;
        e_g0 = e_we && winner == 0;
        e_g1 = e_we && winner == 1;
        e_din = e_g0 ? din0 : (e_g1 ? din1 : 8'h00);
        e_re = rd_req && (mq.size() > 0);
    endtask

    task automatic model_edge();
        bit was_empty;
        was_empty = (mq.size() == 0);
        if (e_re) begin
            m_rdata = mq.pop_front();
            m_rd++;
        end
        m_rv = e_re;
        if (e_we) begin
            mq.push_back(e_din);
            m_wr++;
            m_last = e_g1;
        end
        if (rd_req && was_empty) m_udf = 1'b1;
        else if (err_clr) m_udf = 1'b0;
    endtask

    task automatic check_model();
        chk("gnt0", 32'(gnt0), 32'(e_g0));
        chk("gnt1", 32'(gnt1), 32'(e_g1));
        chk("write_en", 32'(write_en), 32'(e_we));
        chk("data_in", 32'(data_in), 32'(e_din));
        chk("read_en", 32'(read_en), 32'(e_re));
        chk("count", 32'(count), 32'(mq.size()));
        chk("full", 32'(full), 32'(mq.size() == 8));
        chk("empty", 32'(empty), 32'(mq.size() == 0));
        chk("wr_ptr", 32'(wr_ptr), 32'(m_wr % 8));
        chk("rd_ptr", 32'(rd_ptr), 32'(m_rd % 8));
        chk("udf_err", 32'(udf_err), 32'(m_udf));
        chk("rd_valid", 32'(rd_valid), 32'(m_rv));
        if (m_rv) chk("rd_data", 32'(data_out), 32'(m_rdata));
    endtask

    task automatic reset_all();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1; rd_req = 1'b1; err_clr = 1'b0;
        #1;
        chk("rst_gnt0", 32'(gnt0), 32'd0);
        chk("rst_gnt1", 32'(gnt1), 32'd0);
        chk("rst_write_en", 32'(write_en), 32'd0);
        chk("rst_read_en", 32'(read_en), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ptrs", 32'({wr_ptr, rd_ptr}), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_udf", 32'(udf_err), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0; rd_req = 1'b0; err_clr = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit r0; bit r1; logic [7:0] d0; logic [7:0] d1; bit rd; bit clr;
        bit g0; bit g1; logic [7:0] din; bit re; int cnt; int wp; int rp; bit udf;
        bit rv; logic [7:0] dout;
    } vec_t;

    function automatic vec_t mk(bit r0, bit r1, logic [7:0] d0, logic [7:0] d1, bit rd,
                                bit clr, bit g0, bit g1, logic [7:0] din, bit re, int cnt,
                                int wp, int rp, bit udf, bit rv, logic [7:0] dout);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.rd = rd; v.clr = clr;
        v.g0 = g0; v.g1 = g1; v.din = din; v.re = re; v.cnt = cnt; v.wp = wp; v.rp = rp;
        v.udf = udf; v.rv = rv; v.dout = dout;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        bit free0, free1;
        int nexp, nrv;

        //            r0 r1 d0     d1     rd clr g0 g1 din    re cnt wp rp udf rv dout
        tbl[0]  = mk(1, 0, 8'hA5, 8'h00, 0, 0, 1, 0, 8'hA5, 0, 0, 0, 0, 0, 0, 8'h00);
        tbl[1]  = mk(1, 1, 8'h11, 8'h22, 0, 0, 0, 1, 8'h22, 0, 1, 1, 0, 0, 0, 8'h00);
        tbl[2]  = mk(1, 1, 8'h33, 8'h44, 0, 0, 1, 0, 8'h33, 0, 2, 2, 0, 0, 0, 8'h00);
        tbl[3]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 1, 3, 3, 0, 0, 0, 8'h00);
        tbl[4]  = mk(0, 1, 8'h00, 8'h55, 1, 0, 0, 1, 8'h55, 1, 2, 3, 1, 0, 1, 8'hA5);
        tbl[5]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 2, 4, 2, 0, 1, 8'h22);
        tbl[6]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 1, 2, 4, 2, 0, 0, 8'h00);
        tbl[7]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 1, 1, 4, 3, 0, 1, 8'h33);
        tbl[8]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 4, 4, 0, 1, 8'h55);
        tbl[9]  = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 4, 4, 1, 0, 8'h00);
        tbl[10] = mk(0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 4, 4, 1, 0, 8'h00);
        tbl[11] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 4, 4, 0, 0, 8'h00);
        tbl[12] = mk(0, 0, 8'h00, 8'h00, 1, 1, 0, 0, 8'h00, 0, 0, 4, 4, 0, 0, 8'h00);
        tbl[13] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 4, 4, 1, 0, 8'h00);
        tbl[14] = mk(0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 4, 4, 1, 0, 8'h00);
        tbl[15] = mk(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0, 0, 4, 4, 0, 0, 8'h00);

        reset_all();
        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1, tbl[i].rd, tbl[i].clr);
            chk($sformatf("vec%0d_gnt0", i), 32'(gnt0), 32'(tbl[i].g0));
            chk($sformatf("vec%0d_gnt1", i), 32'(gnt1), 32'(tbl[i].g1));
            chk($sformatf("vec%0d_write_en", i), 32'(write_en), 32'(tbl[i].g0 | tbl[i].g1));
            chk($sformatf("vec%0d_data_in", i), 32'(data_in), 32'(tbl[i].din));
            chk($sformatf("vec%0d_read_en", i), 32'(read_en), 32'(tbl[i].re));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
            chk($sformatf("vec%0d_wr_ptr", i), 32'(wr_ptr), 32'(tbl[i].wp));
            chk($sformatf("vec%0d_rd_ptr", i), 32'(rd_ptr), 32'(tbl[i].rp));
            chk($sformatf("vec%0d_udf", i), 32'(udf_err), 32'(tbl[i].udf));
            chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
            if (tbl[i].rv) chk($sformatf("vec%0d_dout", i), 32'(data_out), 32'(tbl[i].dout));
        end

        // Both requesters held: grants alternate starting with requester 0.
        reset_all();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 8'(k), 1'b1, 8'(k + 8), 1'b0, 1'b0);
            chk("alt_gnt0", 32'(gnt0), 32'(k % 2 == 0));
            chk("alt_gnt1", 32'(gnt1), 32'(k % 2 == 1));
        end
        set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("alt_count", 32'(count), 32'd4);
        chk("alt_wr_ptr", 32'(wr_ptr), 32'd4);

        // Full: request stalls, even across a read in the same cycle.
        reset_all();
        for (int k = 0; k < 8; k++) set_in(1'b1, 8'(k), 1'b0, 8'h00, 1'b0, 1'b0);
        set_in(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_gnt0", 32'(gnt0), 32'd0);
        chk("full_write_en", 32'(write_en), 32'd0);
        chk("full_count", 32'(count), 32'd8);
        set_in(1'b1, 8'hEE, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("full_rd_read_en", 32'(read_en), 32'd1);
        chk("full_rd_gnt0", 32'(gnt0), 32'd0);
        set_in(1'b1, 8'hEE, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("after_rd_count", 32'(count), 32'd7);
        chk("after_rd_gnt0", 32'(gnt0), 32'd1);
        set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("refill_count", 32'(count), 32'd8);
        chk("refill_udf", 32'(udf_err), 32'd0);

        // 12 writes/reads interleaved: both pointers wrap, order preserved.
        reset_all();
        nexp = 0;
        nrv = 0;
        for (int k = 0; k < 15; k++) begin
            set_in(k < 12, 8'(8'h30 + k), 1'b0, 8'h00, (k >= 1) && (k <= 12), 1'b0);
            if (rd_valid) begin
                nrv++;
                chk("wrap_data", 32'(data_out), 32'(8'h30 + nexp));
                nexp++;
            end
        end
        chk("wrap_rd_valid_cycles", 32'(nrv), 32'd12);
        chk("wrap_wr_ptr", 32'(wr_ptr), 32'd4);
        chk("wrap_rd_ptr", 32'(rd_ptr), 32'd4);
        chk("wrap_count", 32'(count), 32'd0);

        // Asynchronous reset mid-cycle at count 5.
        reset_all();
        for (int k = 0; k < 5; k++) set_in(1'b1, 8'(k), 1'b0, 8'h00, 1'b0, 1'b0);
        set_in(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_arst_count", 32'(count), 32'd5);
        #2;
        req0 = 1'b1; req1 = 1'b1; rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_ptrs", 32'({wr_ptr, rd_ptr}), 32'd0);
        chk("arst_gnt0", 32'(gnt0), 32'd0);
        chk("arst_write_en", 32'(write_en), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("first_contention_gnt0", 32'(gnt0), 32'd1);
        chk("first_contention_gnt1", 32'(gnt1), 32'd0);

        // Randomized run against the reference model; requests held until granted.
        reset_all();
        free0 = 1'b1;
        free1 = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            int rdpct;
            rdpct = (i < 500) ? 30 : ((i < 1000) ? 75 : 50);
            @(negedge clk);
            if (free0) begin
                req0 = ($urandom % 3) != 0;
                din0 = 8'($urandom);
            end
            if (free1) begin
                req1 = ($urandom % 3) != 0;
                din1 = 8'($urandom);
            end
            rd_req  = ($urandom % 100) < rdpct;
            err_clr = ($urandom % 8) == 0;
            #1;
            model_comb();
            check_model();
            @(posedge clk);
            model_edge();
            free0 = !req0 || e_g0;
            free1 = !req1 || e_g1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 3, pointer width; depth is 2^ADDR_W (8 entries).
REQ-002 clk  in  1  clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 req0  in  1  requester 0 write request; held until granted.
REQ-005 din0  in  8  requester 0 write data.
REQ-006 req1  in  1  requester 1 write request; held until granted.
REQ-007 din1  in  8  requester 1 write data.
REQ-008 gnt0  out  1  requester 0 granted this cycle; the word is written at this edge.
REQ-009 gnt1  out  1  requester 1 granted this cycle; the word is written at this edge.
REQ-010 rd_req  in  1  consumer read request.
REQ-011 err_clr  in  1  clears udf_err.
REQ-012 write_en  out  1  memory write enable.
REQ-013 data_in  out  8  memory write data.
REQ-014 wr_ptr  out  ADDR_W  memory write address.
REQ-015 read_en  out  1  memory read enable.
REQ-016 rd_ptr  out  ADDR_W  memory read address.
REQ-017 rd_valid  out  1  memory data_out holds a newly read word.
REQ-018 full  out  1  count equals 8.
REQ-019 empty  out  1  count equals 0.
REQ-020 count  out  ADDR_W+1  occupancy, 0..8.
REQ-021 udf_err  out  1  sticky underflow flag.

Function
REQ-022 Write path SHALL be combinational from registered state: write_en = (req0|req1) & ~full; at most one grant per cycle.
REQ-023 Arbitration SHALL be round-robin using a registered last-served bit.
  - With one requester active, that requester is granted.
  - With both active, the requester not last served is granted.
  - The last-served bit updates only on a grant.
REQ-024 data_in SHALL be din0 when gnt0 is high, din1 when gnt1 is high, else 8'h00.
REQ-025 When full, gnt0 = gnt1 = write_en = 0 even if a read occurs in the same cycle; requests stay pending, and this is not an error.
REQ-026 read_en SHALL equal rd_req & ~empty, combinationally.
REQ-027 When empty, read_en = 0 even if a write occurs in the same cycle.
REQ-028 rd_valid SHALL be a register: high in the cycle after each read_en, low otherwise, giving 1-cycle read latency.
REQ-029 wr_ptr SHALL increment by 1 modulo 8 on each write.
REQ-030 rd_ptr SHALL increment by 1 modulo 8 on each read; both pointers wrap 7 -> 0.
REQ-031 count SHALL update as follows:
  - +1 on write only.
  - -1 on read only.
  - Unchanged on simultaneous read and write, or neither.
  - Never leaves 0..8.
REQ-032 full and empty SHALL be decoded from count, so they are valid in the same cycle as count.
REQ-033 udf_err SHALL set on any cycle with rd_req & empty and hold until err_clr.
REQ-034 If set and clear coincide, set SHALL win.

Reset
REQ-035 While rst is high, these outputs SHALL be 0: wr_ptr, rd_ptr, count, rd_valid, udf_err, full.
REQ-036 While rst is high, empty SHALL be 1, and gnt0, gnt1, write_en and read_en SHALL be 0 regardless of requests.
REQ-037 Reset SHALL set last-served to requester 1, so requester 0 wins the first contention.
REQ-038 Reset mid-operation SHALL discard all occupancy with no partial pointer update; memory contents are not cleared.

Verification
REQ-039 Reset, then req0=1 din0=8'hA5 for 1 cycle -> gnt0=1, write_en=1, data_in=8'hA5, wr_ptr=0; next cycle count=1, empty=0.
REQ-040 Both requests held for 4 cycles from reset -> grants alternate gnt0, gnt1, gnt0, gnt1 -> count=4, wr_ptr=4.
REQ-041 8 writes then req0 held -> full=1, gnt0=0, count=8; one read -> count=7 next cycle, gnt0=1 the following cycle.
REQ-042 Write 12 words, read 12 words interleaved -> wr_ptr and rd_ptr wrap to 4; data order preserved; rd_valid high exactly 12 cycles.
REQ-043 rd_req=1 while empty -> read_en=0, udf_err=1 sticky; err_clr pulse -> udf_err=0; err_clr together with rd_req while empty -> udf_err stays 1.
REQ-044 At count=5, assert rst asynchronously mid-cycle -> count=0, empty=1 and pointers=0 immediately, without waiting for a clock edge.
